// File: rtl/wide_mult_axi_mult_arb_pkg.sv
// Shared definitions for the wide-multiplier requester arbiter.
// Holds the ID width helper, the statistics counter width, the shadow
// pipeline stage type and a saturating increment helper.
package wide_mult_axi_mult_arb_pkg;

    // Statistics counters are always 32 bits wide.
    localparam int COUNT_W = 32;

    // Largest supported requester count is 8, so three ID bits always suffice.
    // Shadow stages carry the ID zero-extended to this width.
    localparam int MAX_ID_W = 3;

    // Width of a requester index: $clog2 with a floor of one bit.
    function automatic int id_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // One shadow pipeline stage: valid flag plus the issuing requester ID.
    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } shadow_stage_t;

    localparam shadow_stage_t SHADOW_IDLE = '{vld: 1'b0, id: 3'd0};

    // Add one unless already at the all-ones ceiling.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value,
                                                   input logic               inc);
        logic [COUNT_W-1:0] result;
        if (inc && (value != {COUNT_W{1'b1}})) begin
            result = value + COUNT_W'(1);
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/wide_mult_axi_rr_arbiter.sv
// Combinational round-robin picker. Searches upward from rr_ptr, wrapping
// at NUM_REQ-1, and returns the first active request as a one-hot grant
// plus its index. The pointer itself is owned by the parent.
module wide_mult_axi_rr_arbiter
    import wide_mult_axi_mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    // Walk the requesters in priority order starting at rr_ptr; first hit wins.
    always_comb begin
        int   idx_v;
        logic hit_v;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx_v     = 0;
        hit_v     = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx_v      = (int'(rr_ptr) + off) % NUM_REQ;
            hit_v      = enable && !grant_any && req[idx_v];
            grant[idx_v] = grant[idx_v] | hit_v;
            grant_id   = hit_v ? ID_W'(idx_v) : grant_id;
            grant_any  = grant_any | hit_v;
        end
    end

endmodule

// File: rtl/wide_mult_axi_mult_arbiter.sv
// Shares one external pipelined multiplier (fixed latency PIPELINE, stalled
// through mult_clken) among NUM_REQ requesters. A round-robin arbiter issues
// at most one operand pair per cycle; a shadow pipeline of {vld, id} runs in
// lock-step with the multiplier so each product is routed back to the
// requester that issued it. A product whose owner is not ready freezes both
// pipelines, so results always retire in issue order.
//
// Optional build macro MULT_ARB_STATS_EN adds grant_count (per requester,
// saturating) and stall_count (saturating) outputs.
module wide_mult_axi_mult_arbiter
    import wide_mult_axi_mult_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTHA   = 32,
    parameter int WIDTHB   = 32,
    parameter int WIDTHP   = 64,
    parameter int PIPELINE = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*WIDTHA-1:0]   req_dataa,
    input  logic [NUM_REQ*WIDTHB-1:0]   req_datab,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [WIDTHP-1:0]           rsp_result,
    output logic                        mult_clken,
    output logic [WIDTHA-1:0]           mult_dataa,
    output logic [WIDTHB-1:0]           mult_datab,
`ifdef MULT_ARB_STATS_EN
    output logic [NUM_REQ*COUNT_W-1:0]  grant_count,
    output logic [COUNT_W-1:0]          stall_count,
`endif
    input  logic [WIDTHP-1:0]           mult_result
);

    localparam int ID_W = id_w(NUM_REQ);

    // Reject configurations the datapath cannot represent.
    generate
        if (PIPELINE < 1) begin : g_bad_pipeline
            $error("wide_mult_axi_mult_arbiter: PIPELINE must be at least 1");
        end
        if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
            $error("wide_mult_axi_mult_arbiter: NUM_REQ must be in 2..8");
        end
    endgenerate

    shadow_stage_t       shadow_q [PIPELINE];
    shadow_stage_t       shadow_d [PIPELINE];
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rr_ptr_d;
    logic                ready_en_q;
    logic                ready_en_d;

    shadow_stage_t       out_stage_s;
    logic [NUM_REQ-1:0]  out_match_s;
    logic                stall_s;
    logic                arb_enable_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_W-1:0]     grant_id_s;
    logic                grant_any_s;

    // Decode the output shadow stage into per-requester valids and the stall.
    // Reset masks the output so stale products never surface.
    always_comb begin
        out_stage_s = shadow_q[PIPELINE-1];
        out_match_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            out_match_s[i] = out_stage_s.vld && !reset &&
                             (out_stage_s.id == MAX_ID_W'(i));
        end
        stall_s      = |(out_match_s & ~rsp_ready);
        mult_clken   = ~stall_s;
        rsp_valid    = out_match_s;
        rsp_result   = mult_result;
        // No issue while frozen, while in reset, or on the first cycle after it.
        arb_enable_s = ~stall_s & ready_en_q & ~reset;
    end

    wide_mult_axi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (arb_enable_s),
        .grant     (grant_s),
        .grant_id  (grant_id_s),
        .grant_any (grant_any_s)
    );

    // Ready is the grant; operands are an AND-OR mux that rests at zero when idle.
    always_comb begin
        req_ready  = grant_s;
        mult_dataa = '0;
        mult_datab = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mult_dataa = mult_dataa | (req_dataa[i*WIDTHA +: WIDTHA] & {WIDTHA{grant_s[i]}});
            mult_datab = mult_datab | (req_datab[i*WIDTHB +: WIDTHB] & {WIDTHB{grant_s[i]}});
        end
    end

    // Advance the shadow pipeline only on edges where the multiplier advances.
    always_comb begin
        shadow_d = shadow_q;
        if (!stall_s) begin
            shadow_d[0] = '{vld: grant_any_s, id: MAX_ID_W'(grant_id_s)};
            for (int k = 1; k < PIPELINE; k++) begin
                shadow_d[k] = shadow_q[k-1];
            end
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Round-robin pointer moves just past the winner on every transfer.
    always_comb begin
        if (grant_any_s) begin
            if (grant_id_s == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_id_s + ID_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        ready_en_d = 1'b1;
    end

    // Control state: shadow pipeline, arbitration pointer, post-reset guard.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < PIPELINE; k++) begin
                shadow_q[k] <= SHADOW_IDLE;
            end
            rr_ptr_q   <= '0;
            ready_en_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            rr_ptr_q   <= rr_ptr_d;
            ready_en_q <= ready_en_d;
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [COUNT_W-1:0] grant_count_q [NUM_REQ];
    logic [COUNT_W-1:0] grant_count_d [NUM_REQ];
    logic [COUNT_W-1:0] stall_count_q;
    logic [COUNT_W-1:0] stall_count_d;

    // Saturating counts of accepted issues per requester and of frozen cycles.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count_d[i] = sat_inc(grant_count_q[i], grant_s[i]);
            grant_count[i*COUNT_W +: COUNT_W] = grant_count_q[i];
        end
        stall_count_d = sat_inc(stall_count_q, stall_s);
        stall_count   = stall_count_q;
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_count_q[i] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
            stall_count_q <= stall_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_wide_mult_axi_mult_arbiter.sv
// Self-checking bench for wide_mult_axi_mult_arbiter. Includes a behavioural
// clken-stallable multiplier, a scoreboard model (issue-order queue with
// enabled-edge stamps), directed vector tables, corner sequences and a
// randomized run. Statistics checks compile in with MULT_ARB_STATS_EN.
`timescale 1ns/1ps
module tb_wide_mult_axi_mult_arbiter;

    localparam int N    = 4;
    localparam int WA   = 32;
    localparam int WB   = 32;
    localparam int WP   = 64;
    localparam int PIPE = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*WA-1:0] req_dataa;
    logic [N*WB-1:0] req_datab;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [WP-1:0]   rsp_result;
    logic            mult_clken;
    logic [WA-1:0]   mult_dataa;
    logic [WB-1:0]   mult_datab;
    logic [WP-1:0]   mult_result;
`ifdef MULT_ARB_STATS_EN
    logic [N*32-1:0] grant_count;
    logic [31:0]     stall_count;
`endif

    logic [WA-1:0] a_in [N];
    logic [WB-1:0] b_in [N];

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_dataa[i*WA +: WA] = a_in[i];
            req_datab[i*WB +: WB] = b_in[i];
        end
    end

    // Behavioural external multiplier: PIPE enabled edges of latency.
    logic [WP-1:0] mpipe [PIPE];
    always @(posedge clock) begin
        if (mult_clken) begin
            mpipe[0] <= WP'(mult_dataa) * WP'(mult_datab);
            for (int k = 1; k < PIPE; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mult_result = mpipe[PIPE-1];

    wide_mult_axi_mult_arbiter #(
        .NUM_REQ(N), .WIDTHA(WA), .WIDTHB(WB), .WIDTHP(WP), .PIPELINE(PIPE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dataa   (req_dataa),
        .req_datab   (req_datab),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .mult_clken  (mult_clken),
        .mult_dataa  (mult_dataa),
        .mult_datab  (mult_datab),
`ifdef MULT_ARB_STATS_EN
        .grant_count (grant_count),
        .stall_count (stall_count),
`endif
        .mult_result (mult_result)
    );

    // Scoreboard: products in issue order, stamped with the enabled-edge count.
    typedef struct {
        int          id;
        logic [63:0] prod;
        longint      stamp;
    } item_t;
    item_t  sb[$];
    int     rr_m;
    longint en_cnt;
    logic   prev_reset;
    int     tests;
    int     fails;

    logic [N-1:0]  smp_rsp_valid;
    logic [N-1:0]  smp_req_ready;
    logic [WP-1:0] smp_rsp_result;
    logic          smp_clken;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Called at the falling edge: compare outputs with the model, then advance it.
    task automatic model_cycle();
        logic          out_present;
        logic          exp_stall;
        logic [N-1:0]  exp_rv;
        logic [N-1:0]  exp_rdy;
        logic [WA-1:0] exp_a;
        logic [WB-1:0] exp_b;
        int            g;
        int            idx;
        item_t         it;
        out_present = 1'b0;
        exp_stall   = 1'b0;
        exp_rv      = '0;
        if (!reset && sb.size() > 0) begin
            if (en_cnt - sb[0].stamp == longint'(PIPE)) begin
                out_present = 1'b1;
                exp_rv[sb[0].id] = 1'b1;
                exp_stall = !rsp_ready[sb[0].id];
            end
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (out_present) chk("rsp_result", rsp_result, sb[0].prod);
        chk("mult_clken", 64'(mult_clken), 64'(!exp_stall));
        g = -1;
        if (!reset && !prev_reset && !exp_stall) begin
            for (int off = 0; off < N; off++) begin
                idx = (rr_m + off) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        exp_a   = '0;
        exp_b   = '0;
        if (g >= 0) begin
            exp_rdy = oh(g);
            exp_a   = a_in[g];
            exp_b   = b_in[g];
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("mult_dataa", 64'(mult_dataa), 64'(exp_a));
        chk("mult_datab", 64'(mult_datab), 64'(exp_b));
        if (reset) begin
            sb.delete();
            rr_m = 0;
        end else begin
            if (out_present && !exp_stall) void'(sb.pop_front());
            if (g >= 0) begin
                it.id    = g;
                it.prod  = 64'(a_in[g]) * 64'(b_in[g]);
                it.stamp = en_cnt;
                sb.push_back(it);
                rr_m = (g + 1) % N;
            end
        end
        if (!exp_stall) en_cnt++;
        prev_reset     = reset;
        smp_rsp_valid  = rsp_valid;
        smp_req_ready  = req_ready;
        smp_rsp_result = rsp_result;
        smp_clken      = mult_clken;
    endtask

    task automatic tick();
        @(negedge clock);
        model_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_ready", 64'(smp_req_ready), 64'd0);
        chk("post_reset_rsp", 64'(smp_rsp_valid), 64'd0);
    endtask

    task automatic drain(input int cycles);
        req_valid = '0;
        rsp_ready = '1;
        for (int k = 0; k < cycles; k++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int acc;
        int stalls;
        tests = 0;
        fails = 0;
        rr_m = 0;
        en_cnt = 0;
        prev_reset = 1'b1;
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            a_in[i] = '0;
            b_in[i] = '0;
        end
        vecs[0] = '{0, 32'd3,          32'd5,          64'd15};
        vecs[1] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{2, 32'd0,          32'hDEAD_BEEF,  64'd0};
        vecs[3] = '{3, 32'h0001_0000,  32'h0001_0000,  64'h1_0000_0000};
        vecs[4] = '{0, 32'hFFFF_FFFF,  32'd2,          64'h1_FFFF_FFFE};
        vecs[5] = '{2, 32'd12345,      32'd678,        64'd8369910};

        @(posedge clock);
        #1;
        tick();
        do_reset();

        // Table: single requester issues, exact latency and product.
        for (int v = 0; v < 6; v++) begin
            req_valid = oh(vecs[v].id);
            a_in[vecs[v].id] = vecs[v].a;
            b_in[vecs[v].id] = vecs[v].b;
            tick();
            chk("vec_grant", 64'(smp_req_ready), 64'(oh(vecs[v].id)));
            req_valid = '0;
            for (int k = 1; k <= PIPE; k++) begin
                tick();
                if (k < PIPE) begin
                    chk("vec_early", 64'(smp_rsp_valid), 64'd0);
                end else begin
                    chk("vec_rsp_valid", 64'(smp_rsp_valid), 64'(oh(vecs[v].id)));
                    chk("vec_product", smp_rsp_result, vecs[v].p);
                end
            end
        end

        // All requesters busy: grants rotate 0,1,2,3,0..., one product per cycle.
        do_reset();
        req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) begin
                a_in[i] = 32'(100 * k + i + 1);
                b_in[i] = 32'(i + 7);
            end
            tick();
            chk("rr_grant", 64'(smp_req_ready), 64'(oh(k % N)));
            if (k >= PIPE) chk("rr_rsp", 64'(smp_rsp_valid), 64'(oh((k - PIPE) % N)));
        end
        drain(PIPE + 2);

        // Requester 2 withholds rsp_ready for 4 cycles while its product waits.
        do_reset();
        rsp_ready = 4'b1011;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            a_in[i] = 32'(1000 + i);
            b_in[i] = 32'(3 + i);
        end
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (smp_rsp_valid[2]) found = 1;
        end
        chk("stall_wait", 64'(found), 64'd1);
        if (found == 1) begin
            for (int s = 0; s < 4; s++) begin
                if (s > 0) tick();
                chk("stall_clken", 64'(smp_clken), 64'd0);
                chk("stall_ready", 64'(smp_req_ready), 64'd0);
                chk("stall_hold", 64'(smp_rsp_valid), 64'(oh(2)));
            end
            rsp_ready = '1;
            tick();
            chk("stall_release", 64'(smp_rsp_valid), 64'(oh(2)));
            chk("stall_resume", 64'(smp_clken), 64'd1);
        end
`ifdef MULT_ARB_STATS_EN
        chk("stat_stall_4", 64'(stall_count), 64'd4);
`endif
        drain(2 * PIPE + 2);

        // Reset with three products in flight: none may surface, RR restarts at 0.
        do_reset();
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) tick();
        req_valid = '0;
        reset = 1'b1;
        tick();
        chk("rst_mask", 64'(smp_rsp_valid), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < PIPE + 2; k++) begin
            tick();
            chk("rst_flush", 64'(smp_rsp_valid), 64'd0);
        end
        req_valid = '1;
        a_in[0] = 32'd7;
        b_in[0] = 32'd9;
        tick();
        chk("rst_rr_restart", 64'(smp_req_ready), 64'(oh(0)));
        req_valid = '0;
        for (int k = 1; k <= PIPE; k++) tick();
        chk("rst_next_rsp", 64'(smp_rsp_valid), 64'(oh(0)));
        chk("rst_next_prod", smp_rsp_result, 64'd63);
        drain(PIPE + 2);

`ifdef MULT_ARB_STATS_EN
        // Ten issues by requester 1 with exactly four frozen cycles.
        do_reset();
        rsp_ready = 4'b1101;
        acc = 0;
        stalls = 0;
        for (int k = 0; k < 60; k++) begin
            req_valid = (acc < 10) ? 4'b0010 : 4'b0000;
            a_in[1] = 32'(acc + 1);
            b_in[1] = 32'd11;
            tick();
            if (smp_req_ready[1]) acc++;
            if (!smp_clken) stalls++;
            if (stalls >= 4) rsp_ready = '1;
        end
        chk("stat_grant1", 64'(grant_count[63:32]), 64'd10);
        chk("stat_grant0", 64'(grant_count[31:0]), 64'd0);
        chk("stat_stall", 64'(stall_count), 64'd4);
        do_reset();
        chk("stat_grant1_rst", 64'(grant_count[63:32]), 64'd0);
        chk("stat_stall_rst", 64'(stall_count), 64'd0);
`endif

        // Randomized traffic with back-pressure and occasional reset pulses.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       a_in[i] = 32'hFFFF_FFFF;
                    1:       a_in[i] = 32'd0;
                    default: a_in[i] = $urandom;
                endcase
                b_in[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            tick();
        end
        reset = 1'b0;
        tick();
        drain(4 * PIPE + 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wide_mult_axi_mult_arbiter.md
Name: wide_mult_axi_mult_arbiter

Overview:
Shares one pipelined multiplier instance (fixed latency PIPELINE, clken-stallable) among NUM_REQ requesters. Round-robin arbitration issues at most one operand pair per cycle. Each issue is tagged with its requester ID in a shadow pipeline that runs alongside the multiplier, so every product returns to the requester that issued it. Sits between HLS-generated datapath threads and the shared wide multiplier; the multiplier itself stays outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTHA, 32, operand A width
WIDTHB, 32, operand B width
WIDTHP, 64, product width
PIPELINE, 3, multiplier latency in enabled clock edges (>=1; 0 illegal, flagged by elaboration-time check)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_dataa  in  NUM_REQ*WIDTHA  packed operand A, requester i at [i*WIDTHA +: WIDTHA]
req_datab  in  NUM_REQ*WIDTHB  packed operand B
rsp_valid  out  NUM_REQ  product valid for requester i
rsp_ready  in  NUM_REQ  requester i can take product
rsp_result  out  WIDTHP  product, shared by all requesters, qualified by rsp_valid
mult_clken  out  1  to multiplier clken
mult_dataa  out  WIDTHA  to multiplier dataa
mult_datab  out  WIDTHB  to multiplier datab
mult_result  in  WIDTHP  from multiplier result

Behaviour:
- Shadow pipeline: PIPELINE stages of {vld, id[$clog2(NUM_REQ)-1:0]}. Stage k advances only on mult_clken. Output stage = stage PIPELINE-1 (out_vld, out_id).
- stall = out_vld & ~rsp_ready[out_id]. mult_clken = ~stall (combinational).
- rsp_valid[i] = out_vld & (out_id == i). rsp_result = mult_result, passed through with no extra register.
- Arbitration: when stall=0, grant goes to the first requester with req_valid set, searching upward from rr_ptr and wrapping. req_ready = one-hot grant. When stall=1 or no request, req_ready = 0.
- Handshake: transfer when req_valid[i] & req_ready[i]. req_ready never depends on rsp_valid of the same cycle other than through stall.
- Mux: mult_dataa/mult_datab = operands of the granted requester. They are all-zero when there is no grant, which keeps multiplier switching low.
- Stage 0 captures {grant_any, grant_id} on an enabled edge.
- rr_ptr updates to (grant_id+1) mod NUM_REQ on each transfer and holds otherwise. Wrap from NUM_REQ-1 goes to 0.
- Latency: issue at cycle t with no stalls gives rsp_valid at t+PIPELINE. Each stall cycle adds 1.
- Throughput: 1 product/cycle when rsp_ready is high.
- Simultaneous events: a retiring result and a new issue in the same cycle are both allowed when stall=0. If stall=1, nothing retires and nothing issues.
- Back-to-back requests from the same requester: allowed only when it is the sole requester.
- Reset (at any time, including mid-operation): all shadow vld=0, rr_ptr=0, stats counters=0. In-flight products are discarded; the multiplier contents become don't-care because vld=0 masks them. During reset and the cycle after, req_ready=0 and rsp_valid=0.
- Invariant: at most one rsp_valid bit high. Results are delivered in issue order.

Optional Feature:
MULT_ARB_STATS_EN
- Defined: adds output grant_count [NUM_REQ*32] (per-requester count of accepted issues, saturating at 2^32-1) and stall_count [32] (cycles with stall=1, saturating). Both clear on reset.
- Undefined: ports and counters are absent; the other behaviour is identical.

Decomposition:
- Package wide_mult_axi_mult_arb_pkg holds: ID_W function ($clog2 with a minimum of 1), COUNT_W=32, and the shadow-stage struct type {vld, id}.
- One sub-module: wide_mult_axi_rr_arbiter. Inputs: req, rr_ptr, enable. Outputs: one-hot grant, grant_id, grant_any. Purely combinational; rr_ptr is owned by the parent.

Test Plan:
- Single requester 0 issues A=3, B=5 at cycle 10 with rsp_ready=all-1 -> rsp_valid[0] at cycle 13, rsp_result=15, other rsp_valid=0.
- All 4 requesters hold valid continuously, each with unique operands -> grants go 0,1,2,3,0,... One product/cycle; each rsp routed to the matching requester with the correct product; rr_ptr wraps from 3 to 0.
- Requester 2 holds rsp_ready=0 for 4 cycles while its result sits at the output -> mult_clken=0, req_ready=0 for those 4 cycles. No result is lost or duplicated, and the pipeline resumes in order.
- Boundary operands A=0xFFFFFFFF, B=0xFFFFFFFF -> rsp_result=0xFFFFFFFE00000001.
- Assert reset for 1 cycle with 3 products in flight -> no rsp_valid for those products. Next issue after reset returns correctly; grant order restarts at requester 0.
- With MULT_ARB_STATS_EN defined: 10 issues by requester 1 plus 4 stall cycles -> grant_count[1]=10, stall_count=4. Both read 0 after reset.
